eeg_fram_wagen: RTL and testbench

Write-address generator directly upstream of the FRAM write port. It accepts one serial stream of feature words and a per-transfer configuration (base address, words per lane), then distributes the words round-robin across the FRAM lanes. For each lane it drives the per-lane valid/last/address/data write stream that the FRAM consumes on its ETOF_DAT port. It returns to idle once every lane has delivered its last word.

---
 rtl/eeg_fram_pkg.sv | 20 ++
 rtl/eeg_fram_wagen_cnt.sv | 61 ++++++
 rtl/eeg_fram_wagen.sv | 162 ++++++++++++++++
 tb/tb_eeg_fram_wagen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/eeg_fram_pkg.sv
`default_nettype none
// ============================================================================
// Module : eeg_fram_pkg
// Desc   : Shared state encodings and default widths for the FRAM write path.
// Rev    : 1.0
// ============================================================================
package eeg_fram_pkg;

  localparam int FRAM_NUM_DW_DEF = 4;
  localparam int FRAM_ADD_AW_DEF = 12;
  localparam int FRAM_DAT_DW_DEF = 4;

  typedef enum logic [2:0] {
    FRAM_WAGEN_IDLE  = 3'b001,
    FRAM_WAGEN_RUN   = 3'b010,
    FRAM_WAGEN_DRAIN = 3'b100
  } fram_wagen_st_e;

endpackage
`default_nettype wire

// File: rtl/eeg_fram_wagen_cnt.sv
`default_nettype none
// ============================================================================
// Module : EEG_FRAM_WAGEN_CNT
// Desc   : Lane / word index counter pair for the FRAM write-address generator.
// Rev    : 1.0
// ============================================================================
module EEG_FRAM_WAGEN_CNT
  import eeg_fram_pkg::*;
#(
  parameter int FRAM_NUM_DW = FRAM_NUM_DW_DEF,
  parameter int FRAM_ADD_AW = FRAM_ADD_AW_DEF,
  parameter int FRAM_NUM_AW = $clog2(FRAM_NUM_DW)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   inc,
  input  logic [FRAM_ADD_AW-1:0] len_m1,
  output logic [FRAM_NUM_AW-1:0] lane_idx,
  output logic [FRAM_ADD_AW-1:0] wrd_idx,
  output logic                   last
);

  localparam logic [FRAM_NUM_AW-1:0] LANE_MAX = FRAM_NUM_AW'(FRAM_NUM_DW - 1);

  logic [FRAM_NUM_AW-1:0] lane_q, lane_d;
  logic [FRAM_ADD_AW-1:0] wrd_q, wrd_d;

  always_comb begin
    lane_d = lane_q;
    wrd_d  = wrd_q;
    if (clr) begin
      lane_d = '0;
      wrd_d  = '0;
    end else if (inc) begin
      // Lanes advance first; the word index steps once per full lane sweep.
      if (lane_q == LANE_MAX) begin
        lane_d = '0;
        wrd_d  = wrd_q + FRAM_ADD_AW'(1);
      end else begin
        lane_d = lane_q + FRAM_NUM_AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q <= '0;
      wrd_q  <= '0;
    end else begin
      lane_q <= lane_d;
      wrd_q  <= wrd_d;
    end
  end

  assign lane_idx = lane_q;
  assign wrd_idx  = wrd_q;
  assign last     = (lane_q == LANE_MAX) && (wrd_q == len_m1);

endmodule
`default_nettype wire

// File: rtl/eeg_fram_wagen.sv
`default_nettype none
// ============================================================================
// Module : eeg_fram_wagen
// Desc   : Round-robin FRAM write-address generator; optional word counter
//          enabled by FRAM_WAGEN_STAT_EN.
// Rev    : 1.0
// ============================================================================
module eeg_fram_wagen
  import eeg_fram_pkg::*;
#(
  parameter int FRAM_NUM_DW = FRAM_NUM_DW_DEF,
  parameter int FRAM_ADD_AW = FRAM_ADD_AW_DEF,
  parameter int FRAM_DAT_DW = FRAM_DAT_DW_DEF,
  parameter int FRAM_NUM_AW = $clog2(FRAM_NUM_DW)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    CFG_INFO_VLD,
  output logic                                    CFG_INFO_RDY,
  input  logic [FRAM_ADD_AW-1:0]                  CFG_BASE_ADD,
  input  logic [FRAM_ADD_AW-1:0]                  CFG_LEN_M1,
  input  logic                                    IN_DAT_VLD,
  output logic                                    IN_DAT_RDY,
  input  logic [FRAM_DAT_DW-1:0]                  IN_DAT_DAT,
  output logic [FRAM_NUM_DW-1:0]                  ETOF_DAT_VLD,
  output logic [FRAM_NUM_DW-1:0]                  ETOF_DAT_LST,
  input  logic [FRAM_NUM_DW-1:0]                  ETOF_DAT_RDY,
  output logic [FRAM_NUM_DW-1:0][FRAM_ADD_AW-1:0] ETOF_DAT_ADD,
  output logic [FRAM_NUM_DW-1:0][FRAM_DAT_DW-1:0] ETOF_DAT_DAT
`ifdef FRAM_WAGEN_STAT_EN
  ,
  output logic [FRAM_ADD_AW+FRAM_NUM_AW:0]        STAT_WRD_CNT
`endif
);

  fram_wagen_st_e state_q, state_d;

  logic [FRAM_ADD_AW-1:0] base_q, base_d;
  logic [FRAM_ADD_AW-1:0] len_m1_q, len_m1_d;

  logic                   out_vld_q, out_vld_d;
  logic [FRAM_NUM_AW-1:0] out_lane_q, out_lane_d;
  logic [FRAM_ADD_AW-1:0] out_add_q, out_add_d;
  logic [FRAM_DAT_DW-1:0] out_dat_q, out_dat_d;
  logic                   out_lst_q, out_lst_d;

  logic [FRAM_NUM_AW-1:0] w_lane_idx;
  logic [FRAM_ADD_AW-1:0] w_wrd_idx;
  logic                   w_last;
  logic                   w_cfg_acc;
  logic                   w_in_acc;
  logic                   w_out_ena;

  assign CFG_INFO_RDY = (state_q == FRAM_WAGEN_IDLE);
  assign w_cfg_acc    = CFG_INFO_VLD & CFG_INFO_RDY;
  assign w_out_ena    = out_vld_q & ETOF_DAT_RDY[out_lane_q];
  assign IN_DAT_RDY   = (state_q == FRAM_WAGEN_RUN) & (~out_vld_q | w_out_ena);
  assign w_in_acc     = IN_DAT_VLD & IN_DAT_RDY;

  EEG_FRAM_WAGEN_CNT #(
    .FRAM_NUM_DW (FRAM_NUM_DW),
    .FRAM_ADD_AW (FRAM_ADD_AW),
    .FRAM_NUM_AW (FRAM_NUM_AW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_cfg_acc),
    .inc      (w_in_acc),
    .len_m1   (len_m1_q),
    .lane_idx (w_lane_idx),
    .wrd_idx  (w_wrd_idx),
    .last     (w_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      FRAM_WAGEN_IDLE:  if (w_cfg_acc) state_d = FRAM_WAGEN_RUN;
      FRAM_WAGEN_RUN:   if (w_in_acc && w_last) state_d = FRAM_WAGEN_DRAIN;
      FRAM_WAGEN_DRAIN: if (w_out_ena) state_d = FRAM_WAGEN_IDLE;
      default:          state_d = FRAM_WAGEN_IDLE;
    endcase
  end

  always_comb begin
    base_d     = base_q;
    len_m1_d   = len_m1_q;
    out_vld_d  = out_vld_q;
    out_lane_d = out_lane_q;
    out_add_d  = out_add_q;
    out_dat_d  = out_dat_q;
    out_lst_d  = out_lst_q;
    if (w_cfg_acc) begin
      base_d   = CFG_BASE_ADD;
      len_m1_d = CFG_LEN_M1;
    end
    // A load wins over a drain so the register refills in the same cycle.
    if (w_in_acc) begin
      out_vld_d  = 1'b1;
      out_lane_d = w_lane_idx;
      out_add_d  = base_q + w_wrd_idx;
      out_dat_d  = IN_DAT_DAT;
      out_lst_d  = (w_wrd_idx == len_m1_q);
    end else if (w_out_ena) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FRAM_WAGEN_IDLE;
      base_q     <= '0;
      len_m1_q   <= '0;
      out_vld_q  <= 1'b0;
      out_lane_q <= '0;
      out_add_q  <= '0;
      out_dat_q  <= '0;
      out_lst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_m1_q   <= len_m1_d;
      out_vld_q  <= out_vld_d;
      out_lane_q <= out_lane_d;
      out_add_q  <= out_add_d;
      out_dat_q  <= out_dat_d;
      out_lst_q  <= out_lst_d;
    end
  end

  for (genvar i = 0; i < FRAM_NUM_DW; i++) begin : g_lane
    assign ETOF_DAT_VLD[i] = out_vld_q & (out_lane_q == FRAM_NUM_AW'(i));
    assign ETOF_DAT_LST[i] = out_vld_q & out_lst_q & (out_lane_q == FRAM_NUM_AW'(i));
    assign ETOF_DAT_ADD[i] = out_add_q;
    assign ETOF_DAT_DAT[i] = out_dat_q;
  end

`ifdef FRAM_WAGEN_STAT_EN
  logic [FRAM_ADD_AW+FRAM_NUM_AW:0] stat_cnt_q, stat_cnt_d;

  always_comb begin
    stat_cnt_d = stat_cnt_q;
    if (w_cfg_acc) begin
      stat_cnt_d = '0;
    end else if (w_out_ena) begin
      stat_cnt_d = stat_cnt_q + (FRAM_ADD_AW+FRAM_NUM_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cnt_q <= '0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign STAT_WRD_CNT = stat_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eeg_fram_wagen.sv
`default_nettype none
// ============================================================================
// Module : tb_eeg_fram_wagen
// Desc   : Directed, table-driven bench for eeg_fram_wagen (4 lanes, 12b/4b).
// Rev    : 1.0
// ============================================================================
module tb_eeg_fram_wagen;

  logic             clk;
  logic             rst_n;
  logic             CFG_INFO_VLD;
  logic             CFG_INFO_RDY;
  logic [11:0]      CFG_BASE_ADD;
  logic [11:0]      CFG_LEN_M1;
  logic             IN_DAT_VLD;
  logic             IN_DAT_RDY;
  logic [3:0]       IN_DAT_DAT;
  logic [3:0]       ETOF_DAT_VLD;
  logic [3:0]       ETOF_DAT_LST;
  logic [3:0]       ETOF_DAT_RDY;
  logic [3:0][11:0] ETOF_DAT_ADD;
  logic [3:0][3:0]  ETOF_DAT_DAT;
`ifdef FRAM_WAGEN_STAT_EN
  logic [14:0]      STAT_WRD_CNT;
`endif

  eeg_fram_wagen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .CFG_INFO_VLD (CFG_INFO_VLD),
    .CFG_INFO_RDY (CFG_INFO_RDY),
    .CFG_BASE_ADD (CFG_BASE_ADD),
    .CFG_LEN_M1   (CFG_LEN_M1),
    .IN_DAT_VLD   (IN_DAT_VLD),
    .IN_DAT_RDY   (IN_DAT_RDY),
    .IN_DAT_DAT   (IN_DAT_DAT),
    .ETOF_DAT_VLD (ETOF_DAT_VLD),
    .ETOF_DAT_LST (ETOF_DAT_LST),
    .ETOF_DAT_RDY (ETOF_DAT_RDY),
    .ETOF_DAT_ADD (ETOF_DAT_ADD),
    .ETOF_DAT_DAT (ETOF_DAT_DAT)
`ifdef FRAM_WAGEN_STAT_EN
    ,
    .STAT_WRD_CNT (STAT_WRD_CNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dat;
    logic [1:0]  lane;
    logic [11:0] add;
    logic        lst;
  } vec_t;

  vec_t tbl[16];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [11:0] base, input logic [11:0] len_m1);
    CFG_INFO_VLD = 1'b1;
    CFG_BASE_ADD = base;
    CFG_LEN_M1   = len_m1;
    #1;
    chk("cfg_rdy_idle", 32'(CFG_INFO_RDY), 32'd1);
    tick();
    CFG_INFO_VLD = 1'b0;
    chk("cfg_rdy_run", 32'(CFG_INFO_RDY), 32'd0);
    chk("in_rdy_after_cfg", 32'(IN_DAT_RDY), 32'd1);
  endtask

  // Present one word, expect it accepted, then expect it on its lane next cycle.
  task automatic send(input vec_t v);
    logic [3:0] onehot;
    onehot     = 4'b0001 << v.lane;
    IN_DAT_VLD = 1'b1;
    IN_DAT_DAT = v.dat;
    #1;
    chk("in_rdy", 32'(IN_DAT_RDY), 32'd1);
    tick();
    chk("etof_vld", 32'(ETOF_DAT_VLD), 32'(onehot));
    chk("etof_lst", 32'(ETOF_DAT_LST), v.lst ? 32'(onehot) : 32'd0);
    chk("etof_add", 32'(ETOF_DAT_ADD[v.lane]), 32'(v.add));
    chk("etof_dat", 32'(ETOF_DAT_DAT[v.lane]), 32'(v.dat));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    // Group 0: base 0x010, len_m1=1.  Group 1: base 0xFFF, len_m1=1 (wrap).
    tbl[0]  = '{4'h0, 2'd0, 12'h010, 1'b0};
    tbl[1]  = '{4'h1, 2'd1, 12'h010, 1'b0};
    tbl[2]  = '{4'h2, 2'd2, 12'h010, 1'b0};
    tbl[3]  = '{4'h3, 2'd3, 12'h010, 1'b0};
    tbl[4]  = '{4'h4, 2'd0, 12'h011, 1'b1};
    tbl[5]  = '{4'h5, 2'd1, 12'h011, 1'b1};
    tbl[6]  = '{4'h6, 2'd2, 12'h011, 1'b1};
    tbl[7]  = '{4'h7, 2'd3, 12'h011, 1'b1};
    tbl[8]  = '{4'h8, 2'd0, 12'hFFF, 1'b0};
    tbl[9]  = '{4'h9, 2'd1, 12'hFFF, 1'b0};
    tbl[10] = '{4'hA, 2'd2, 12'hFFF, 1'b0};
    tbl[11] = '{4'hB, 2'd3, 12'hFFF, 1'b0};
    tbl[12] = '{4'hC, 2'd0, 12'h000, 1'b1};
    tbl[13] = '{4'hD, 2'd1, 12'h000, 1'b1};
    tbl[14] = '{4'hE, 2'd2, 12'h000, 1'b1};
    tbl[15] = '{4'hF, 2'd3, 12'h000, 1'b1};

    rst_n        = 1'b0;
    CFG_INFO_VLD = 1'b0;
    CFG_BASE_ADD = '0;
    CFG_LEN_M1   = '0;
    IN_DAT_VLD   = 1'b0;
    IN_DAT_DAT   = '0;
    ETOF_DAT_RDY = 4'hF;
    tick();
    tick();
    chk("rst_vld", 32'(ETOF_DAT_VLD), 32'd0);
    chk("rst_lst", 32'(ETOF_DAT_LST), 32'd0);
    chk("rst_add", 32'(ETOF_DAT_ADD), 32'd0);
    chk("rst_dat", 32'(ETOF_DAT_DAT), 32'd0);
    chk("rst_in_rdy", 32'(IN_DAT_RDY), 32'd0);
    chk("rst_cfg_rdy", 32'(CFG_INFO_RDY), 32'd1);
`ifdef FRAM_WAGEN_STAT_EN
    chk("rst_stat", 32'(STAT_WRD_CNT), 32'd0);
`endif
    rst_n = 1'b1;

    for (int g = 0; g < 2; g++) begin
      cfg((g == 0) ? 12'h010 : 12'hFFF, 12'd1);
`ifdef FRAM_WAGEN_STAT_EN
      if (g == 1) chk("stat_clr_on_cfg", 32'(STAT_WRD_CNT), 32'd0);
`endif
      for (int i = 0; i < 8; i++) send(tbl[g*8 + i]);
      IN_DAT_VLD = 1'b0;
      chk("drain_cfg_rdy", 32'(CFG_INFO_RDY), 32'd0);
      chk("drain_in_rdy", 32'(IN_DAT_RDY), 32'd0);
      tick();
      chk("idle_cfg_rdy", 32'(CFG_INFO_RDY), 32'd1);
      chk("idle_vld", 32'(ETOF_DAT_VLD), 32'd0);
`ifdef FRAM_WAGEN_STAT_EN
      if (g == 0) chk("stat_cnt", 32'(STAT_WRD_CNT), 32'd8);
`endif
    end

    // Backpressure on lane 2 with a stray config pulse while running.
    cfg(12'h100, 12'd0);
    ETOF_DAT_RDY = 4'b1011;
    v = '{4'hA, 2'd0, 12'h100, 1'b1}; send(v);
    v = '{4'hB, 2'd1, 12'h100, 1'b1}; send(v);
    v = '{4'hC, 2'd2, 12'h100, 1'b1}; send(v);
    IN_DAT_VLD = 1'b1;
    IN_DAT_DAT = 4'h5;
    for (int k = 0; k < 5; k++) begin
      CFG_INFO_VLD = (k == 2);
      CFG_BASE_ADD = 12'h555;
      CFG_LEN_M1   = 12'd3;
      #1;
      chk("bp_in_rdy", 32'(IN_DAT_RDY), 32'd0);
      chk("bp_cfg_rdy", 32'(CFG_INFO_RDY), 32'd0);
      tick();
      chk("bp_vld", 32'(ETOF_DAT_VLD), 32'b0100);
      chk("bp_lst", 32'(ETOF_DAT_LST), 32'b0100);
      chk("bp_add", 32'(ETOF_DAT_ADD[2]), 32'h100);
      chk("bp_dat", 32'(ETOF_DAT_DAT[2]), 32'hC);
    end
    CFG_INFO_VLD = 1'b0;
    ETOF_DAT_RDY = 4'hF;
    v = '{4'hD, 2'd3, 12'h100, 1'b1}; send(v);
    IN_DAT_VLD = 1'b0;
    tick();
    chk("bp_done_cfg_rdy", 32'(CFG_INFO_RDY), 32'd1);
    chk("bp_done_vld", 32'(ETOF_DAT_VLD), 32'd0);

    // Reset after three words, then a fresh single-word-per-lane transfer.
    cfg(12'h040, 12'd1);
    for (int i = 0; i < 3; i++) begin
      v = '{4'(i + 1), 2'(i), 12'h040, 1'b0};
      send(v);
    end
    IN_DAT_VLD = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_vld", 32'(ETOF_DAT_VLD), 32'd0);
    chk("mrst_lst", 32'(ETOF_DAT_LST), 32'd0);
    chk("mrst_cfg_rdy", 32'(CFG_INFO_RDY), 32'd1);
    chk("mrst_in_rdy", 32'(IN_DAT_RDY), 32'd0);
    cfg(12'h020, 12'd0);
    for (int i = 0; i < 4; i++) begin
      v = '{4'(i + 9), 2'(i), 12'h020, 1'b1};
      send(v);
    end
    IN_DAT_VLD = 1'b0;
    tick();
    chk("mrst_done_cfg_rdy", 32'(CFG_INFO_RDY), 32'd1);
`ifdef FRAM_WAGEN_STAT_EN
    chk("mrst_stat", 32'(STAT_WRD_CNT), 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
